echo_msg_serializer: RTL and testbench
======================================

Name: echo_msg_serializer

Overview:
Reader/drain side of the 704-bit single-entry echo message FIFO. It pops one wide message (fields a, b, c0..c19) through the FIFO's first/deq methods and emits it as 22 sequential 32-bit beats on a narrow enq-style stream toward the host transport, with a last-beat flag. It sits between the wide message FIFO and the 32-bit indication channel.

Parameters:
WORD_WIDTH, 32, width of one output beat.
NUM_WORDS, 22, beats per message; message width = WORD_WIDTH*NUM_WORDS = 704.
CNT_WIDTH, 5, beat index width, equal to clog2(NUM_WORDS).

Ports:
CLK  input  1  clock, all state on rising edge.
nRST  input  1  reset, asynchronous, active-low.
in$first  input  704  head message from the FIFO; word 0 = bits [31:0] (field a), word 21 = bits [703:672] (c19).
in$first__RDY  input  1  head message valid.
in$deq__RDY  input  1  FIFO can dequeue.
in$deq__ENA  output  1  dequeue strobe, one cycle per message.
out$enq__ENA  output  1  beat valid.
out$enq$v  output  32  beat data.
out$enq$last  output  1  high on beat NUM_WORDS-1 only.
out$enq__RDY  input  1  downstream accepts beat.
msg_count  output  32  messages fully sent, wraps 0xFFFFFFFF -> 0.

Behaviour:
- Reset (nRST low, asynchronous, any cycle): state IDLE, beat index 0, shift register 0, msg_count 0. Outputs in$deq__ENA=0, out$enq__ENA=0, out$enq$v=0, out$enq$last=0. A message partly sent is dropped. The FIFO entry was already dequeued at capture, so it is lost and is not re-sent.
- States: IDLE (no message held) and SEND (message held, beats pending).
- take = in$first__RDY & in$deq__RDY & (state==IDLE | last_accept). take is combinational; in$deq__ENA = take.
- beat_accept = out$enq__ENA & out$enq__RDY. last_accept = beat_accept & (index==NUM_WORDS-1).
- On take:
  - the shift register loads in$first in the same cycle;
  - the index goes to 0;
  - the state goes to (or stays in) SEND.
- SEND:
  - out$enq__ENA=1; out$enq$v = shift register bits [31:0], driven from a register, not combinational from in$first.
  - out$enq$last = (index==NUM_WORDS-1).
  - On beat_accept without last: shift right by WORD_WIDTH, fill with zero, index+1.
  - On last_accept: msg_count+1. Then take if it fires, else go to IDLE.
- Zero-bubble: back-to-back messages produce a continuous 22*N-beat stream with no idle cycle.
- Latency: message present in IDLE -> first beat valid on the next cycle.
- Backpressure: while out$enq__RDY=0, data, last and index hold stable, and out$enq__ENA stays high (it is never withdrawn).
- in$deq__ENA never asserts in SEND unless the final beat is being accepted in that cycle.
- Data and flag outputs have no combinational path from in$first. The combinational paths out$enq__RDY -> in$deq__ENA and in$deq__RDY -> in$deq__ENA are permitted.

Decomposition:
- Shared package holds:
  - ECHO_WORD_WIDTH=32, ECHO_NUM_WORDS=22, ECHO_MSG_WIDTH=704;
  - a state enum {IDLE, SEND};
  - a packed echo message struct {c19..c0, b, a}, with a at the LSB.
- The FIFO and the matching deserializer share this package.
- No sub-module needed. The beat counter and shift register stay inline.

Test Plan:
- Single message, out$enq__RDY always 1, input words k = 0x1000+k. Required: in$deq__ENA pulses once, exactly 22 beats 0x1000..0x1015, last only on 0x1015, msg_count=1, then IDLE with ENA=0.
- Random out$enq__RDY (50%). Required: beat sequence identical to the previous case, data and last stable while stalled, no beat skipped or duplicated.
- Three messages queued back-to-back. Required: 66 consecutive valid cycles; in$deq__ENA in the same cycle as beats 21 and 43; msg_count=3.
- in$first__RDY high but in$deq__RDY low. Required: no dequeue and no beats. When in$deq__RDY rises: dequeue, and the first beat appears the next cycle.
- nRST asserted mid-message at beat 9, asynchronously between clock edges. Required: outputs go to 0 immediately, msg_count=0. After release with a new message: beat 0 of the new message, old data not resumed.
- Preload msg_count=0xFFFFFFFF (force), send one message. Required: msg_count=0.

Source files
------------

// File: rtl/echo_msg_serializer_pkg.sv
// Shared definitions for the 704-bit echo message path (FIFO, serializer, deserializer).
package echo_msg_serializer_pkg;

  localparam int ECHO_WORD_WIDTH = 32;
  localparam int ECHO_NUM_WORDS  = 22;
  localparam int ECHO_MSG_WIDTH  = ECHO_WORD_WIDTH * ECHO_NUM_WORDS;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } echo_state_e;

  // Field a sits at the LSB so word 0 of the beat stream is a.
  typedef struct packed {
    logic [31:0] c19, c18, c17, c16, c15, c14, c13, c12, c11, c10;
    logic [31:0] c9, c8, c7, c6, c5, c4, c3, c2, c1, c0;
    logic [31:0] b;
    logic [31:0] a;
  } echo_msg_t;

endpackage

// File: rtl/echo_msg_serializer.sv
// Drains one wide echo message from the FIFO and emits it as NUM_WORDS
// registered 32-bit beats, reloading on the final beat for a gap-free stream.
module echo_msg_serializer
  import echo_msg_serializer_pkg::*;
#(
  parameter int WORD_WIDTH = ECHO_WORD_WIDTH,
  parameter int NUM_WORDS  = ECHO_NUM_WORDS,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0]  in_first,
  input  logic                             in_first_rdy,
  input  logic                             in_deq_rdy,
  output logic                             in_deq_ena,
  output logic                             out_enq_ena,
  output logic [WORD_WIDTH-1:0]            out_enq_v,
  output logic                             out_enq_last,
  input  logic                             out_enq_rdy,
  output logic [31:0]                      msg_count
);

  localparam int MSG_WIDTH = WORD_WIDTH * NUM_WORDS;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

  echo_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]   idx_q, idx_d;
  logic [MSG_WIDTH-1:0]   shift_q, shift_d;
  logic [31:0]            msg_count_q, msg_count_d;

  logic sending;
  logic beat_accept;
  logic last_accept;
  logic take;

  assign sending     = (state_q == SEND);
  assign beat_accept = sending & out_enq_rdy;
  assign last_accept = beat_accept & (idx_q == LAST_IDX);
  // Reload on the final accepted beat so consecutive messages leave no bubble.
  assign take        = in_first_rdy & in_deq_rdy & (~sending | last_accept);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    msg_count_d = msg_count_q;

    if (last_accept) begin
      msg_count_d = msg_count_q + 32'd1;
    end

    if (take) begin
      shift_d = in_first;
      idx_d   = '0;
      state_d = SEND;
    end else if (last_accept) begin
      shift_d = '0;
      idx_d   = '0;
      state_d = IDLE;
    end else if (beat_accept) begin
      shift_d = shift_q >> WORD_WIDTH;
      idx_d   = idx_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign in_deq_ena   = take;
  assign out_enq_ena  = sending;
  assign out_enq_v    = shift_q[WORD_WIDTH-1:0];
  assign out_enq_last = sending & (idx_q == LAST_IDX);
  assign msg_count    = msg_count_q;

endmodule

// File: tb/tb_echo_msg_serializer.sv
// Randomized self-checking bench for echo_msg_serializer against a queue-based beat model.
module tb_echo_msg_serializer;

  logic         clk;
  logic         rst_n;
  logic [703:0] first;
  logic         first_rdy;
  logic         deq_rdy;
  logic         deq_ena;
  logic         ena;
  logic [31:0]  v;
  logic         last;
  logic         out_rdy;
  logic [31:0]  msg_count;

  int          checks;
  int          passes;
  logic [31:0] mc_model;
  int          s_deq_cnt;
  int          s_run;
  int          s_deq_pos[$];

  echo_msg_serializer dut (
    .CLK          (clk),
    .nRST         (rst_n),
    .in_first     (first),
    .in_first_rdy (first_rdy),
    .in_deq_rdy   (deq_rdy),
    .in_deq_ena   (deq_ena),
    .out_enq_ena  (ena),
    .out_enq_v    (v),
    .out_enq_last (last),
    .out_enq_rdy  (out_rdy),
    .msg_count    (msg_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Feeds nmsg messages through an emulated FIFO and checks every beat,
  // the dequeue strobe rule, stall stability and the final idle state.
  task automatic stream(input int nmsg, input int rdy_pct, input bit fixed);
    logic [703:0] pend[$];
    logic [31:0]  exp_v[$];
    bit           exp_l[$];
    bit           hold;
    logic [31:0]  hv;
    logic         hl;
    logic         exp_deq;
    int           beats, run, cyc;
    pend = {}; exp_v = {}; exp_l = {};
    for (int m = 0; m < nmsg; m++) begin
      logic [703:0] msg;
      for (int k = 0; k < 22; k++) begin
        logic [31:0] w;
        w = fixed ? 32'(32'h1000 + k) : 32'($urandom);
        msg[k*32 +: 32] = w;
        exp_v.push_back(w);
        exp_l.push_back(k == 21);
      end
      pend.push_back(msg);
    end
    s_deq_cnt = 0; s_run = 0; s_deq_pos = {};
    beats = 0; run = 0; hold = 0; cyc = 0; hv = '0; hl = 1'b0;
    while ((exp_v.size() > 0 || pend.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      out_rdy   = ($urandom_range(99) < rdy_pct);
      deq_rdy   = 1'b1;
      first_rdy = (pend.size() > 0);
      first     = first_rdy ? pend[0] : '0;
      #1;
      if (hold) begin
        checks++;
        if (ena !== 1'b1 || v !== hv || last !== hl)
          $display("FAIL stall_hold: ena=%b v=%h last=%b, required ena=1 v=%h last=%b", ena, v, last, hv, hl);
        else passes++;
      end
      hold = 0;
      exp_deq = first_rdy && (!ena || (out_rdy && last));
      checks++;
      if (deq_ena !== exp_deq)
        $display("FAIL deq_strobe: got %b, required %b (beat %0d)", deq_ena, exp_deq, beats);
      else passes++;
      if (ena) begin
        run++;
        if (run > s_run) s_run = run;
      end else run = 0;
      if (deq_ena) begin
        s_deq_cnt++;
        s_deq_pos.push_back((ena && out_rdy) ? beats : -1);
        if (pend.size() > 0) void'(pend.pop_front());
      end
      if (ena && out_rdy) begin
        checks++;
        if (exp_v.size() == 0)
          $display("FAIL extra_beat: got v=%h last=%b, required no beat", v, last);
        else if (v !== exp_v[0] || last !== exp_l[0])
          $display("FAIL beat_%0d: got v=%h last=%b, required v=%h last=%b", beats, v, last, exp_v[0], exp_l[0]);
        else passes++;
        if (exp_v.size() > 0) begin
          void'(exp_v.pop_front());
          void'(exp_l.pop_front());
        end
        beats++;
      end else if (ena) begin
        hold = 1; hv = v; hl = last;
      end
      cyc++;
    end
    checks++;
    if (cyc >= 5000) $display("FAIL stream_timeout: got %0d beats, required %0d", beats, nmsg * 22);
    else passes++;
    @(negedge clk);
    first_rdy = 1'b0; first = '0; out_rdy = 1'b1;
    #1;
    mc_model = mc_model + 32'(nmsg);
    checks++;
    if (ena !== 1'b0 || deq_ena !== 1'b0 || msg_count !== mc_model)
      $display("FAIL stream_end: ena=%b deq=%b count=%h, required ena=0 deq=0 count=%h", ena, deq_ena, msg_count, mc_model);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; first = '0; first_rdy = 0; deq_rdy = 0; out_rdy = 0;
    mc_model = '0;
    #12;
    checks++;
    if (ena !== 0 || v !== 0 || last !== 0 || deq_ena !== 0 || msg_count !== 0)
      $display("FAIL reset_state: ena=%b v=%h last=%b deq=%b count=%h, required all 0", ena, v, last, deq_ena, msg_count);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    stream(1, 100, 1);
    checks++;
    if (s_deq_cnt !== 1) $display("FAIL single_deq_count: got %0d, required 1", s_deq_cnt);
    else passes++;
  endtask

  task automatic test_backpressure();
    stream(1, 50, 1);
    stream(2, 50, 0);
    checks++;
    if (s_deq_cnt !== 2) $display("FAIL bp_deq_count: got %0d, required 2", s_deq_cnt);
    else passes++;
  endtask

  task automatic test_back_to_back();
    stream(3, 100, 0);
    checks++;
    if (s_run !== 66) $display("FAIL b2b_run: got %0d valid cycles, required 66", s_run);
    else passes++;
    checks++;
    if (s_deq_pos.size() !== 3 || s_deq_pos[0] !== -1 || s_deq_pos[1] !== 21 || s_deq_pos[2] !== 43)
      $display("FAIL b2b_deq_pos: got %p, required '{-1,21,43}", s_deq_pos);
    else passes++;
  endtask

  task automatic test_deq_gate();
    logic [703:0] msg;
    for (int k = 0; k < 22; k++) msg[k*32 +: 32] = $urandom;
    @(negedge clk);
    first = msg; first_rdy = 1'b1; deq_rdy = 1'b0; out_rdy = 1'b1;
    repeat (4) begin
      #1;
      checks++;
      if (deq_ena !== 0 || ena !== 0) $display("FAIL gate_hold: deq=%b ena=%b, required 0 0", deq_ena, ena);
      else passes++;
      @(negedge clk);
    end
    deq_rdy = 1'b1;
    #1;
    checks++;
    if (deq_ena !== 1'b1) $display("FAIL gate_deq: got %b, required 1", deq_ena);
    else passes++;
    @(negedge clk);
    first_rdy = 1'b0;
    #1;
    checks++;
    if (ena !== 1'b1 || v !== msg[31:0] || last !== 1'b0)
      $display("FAIL gate_latency: ena=%b v=%h last=%b, required 1 %h 0", ena, v, last, msg[31:0]);
    else passes++;
    repeat (21) @(negedge clk);
    #1;
    checks++;
    if (ena !== 1'b1 || v !== msg[703:672] || last !== 1'b1)
      $display("FAIL gate_last: ena=%b v=%h last=%b, required 1 %h 1", ena, v, last, msg[703:672]);
    else passes++;
    @(negedge clk);
    #1;
    mc_model = mc_model + 32'd1;
    checks++;
    if (ena !== 1'b0 || msg_count !== mc_model)
      $display("FAIL gate_done: ena=%b count=%h, required 0 %h", ena, msg_count, mc_model);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [703:0] msg;
    for (int k = 0; k < 22; k++) msg[k*32 +: 32] = $urandom;
    @(negedge clk);
    first = msg; first_rdy = 1'b1; deq_rdy = 1'b1; out_rdy = 1'b1;
    #1;
    checks++;
    if (deq_ena !== 1'b1) $display("FAIL rst_mid_take: got %b, required 1", deq_ena);
    else passes++;
    @(negedge clk);
    first_rdy = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    checks++;
    if (ena !== 1'b1 || v !== msg[9*32 +: 32])
      $display("FAIL rst_mid_beat9: ena=%b v=%h, required 1 %h", ena, v, msg[9*32 +: 32]);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    mc_model = '0;
    checks++;
    if (ena !== 0 || v !== 0 || last !== 0 || deq_ena !== 0 || msg_count !== 0)
      $display("FAIL rst_mid_async: ena=%b v=%h last=%b deq=%b count=%h, required all 0", ena, v, last, deq_ena, msg_count);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    stream(1, 100, 0);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.msg_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.msg_count_q;
    mc_model = 32'hFFFF_FFFF;
    stream(1, 100, 0);
    checks++;
    if (msg_count !== 32'd0) $display("FAIL count_wrap: got %h, required 00000000", msg_count);
    else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_deq_gate();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
